sprite_fetch: RTL and testbench

- Initiator side of the sprite/frame ROM read port.
- On a start request, walks one 20x20 sprite (400 words) starting at a base address, drives ROM read addresses and absorbs the ROM's fixed 1-cycle registered read latency.
- Emits a valid/ready pixel stream tagged with in-sprite x/y, which feeds the tetris block renderer and the frame composer.
- A small credit-tracked FIFO gives full throughput under backpressure without losing in-flight ROM data.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_fifo.sv | 58 +++++
 rtl/sprite_fetch.sv | 132 +++++++++++++
 tb/tb_sprite_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM fetch path.
// Latency: n/a (types only).
// Backpressure: n/a.
package sprite_pkg;

  localparam int SPR_W      = 20;
  localparam int SPR_H      = 20;
  localparam int SPR_PIXELS = SPR_W * SPR_H;
  localparam int ROM_ADDR_W = 19;
  localparam int PIX_W      = 24;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/sprite_fifo.sv
// Small synchronous FIFO with occupancy count.
// Latency: a push is visible at rd_data the cycle after the push edge.
// Backpressure: pop on empty is ignored; the writer must keep its own credit (count) so it never pushes into a full FIFO.
//
// Ports: Clk/Reset_n (async active-low), push + wr_data, pop, rd_data (head entry),
//        count (entries held), empty.
module sprite_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit accounting must make overflow impossible.
  a_no_overflow: assert property (@(posedge Clk) disable iff (!Reset_n) !(push && full));
  a_count_bound: assert property (@(posedge Clk) disable iff (!Reset_n) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/sprite_fetch.sv
// Walks one SPR_W x SPR_H sprite out of the ROM and streams it as tagged pixels.
// Latency: first pix_valid 2 cycles after the accepting edge; 1 pixel/cycle when pix_ready is held high.
// Backpressure: issue is throttled by fifo_count + in-flight reads, so stalls never drop ROM data.
//
// Ports: Clk, Reset_n (async active-low); start/base_addr request, busy/done status;
//        rom_addr out / rom_data in (1-cycle registered ROM);
//        pix_valid/pix_ready handshake with pix_data, pix_x, pix_y, pix_last.
module sprite_fetch #(
  parameter int SPR_W      = sprite_pkg::SPR_W,
  parameter int SPR_H      = sprite_pkg::SPR_H,
  parameter int ADDR_W     = sprite_pkg::ROM_ADDR_W,
  parameter int DATA_W     = sprite_pkg::PIX_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [4:0]        pix_x,
  output logic [4:0]        pix_y,
  output logic              pix_last
);

  import sprite_pkg::*;

  localparam int NPIX  = SPR_W * SPR_H;
  localparam int IDX_W = $clog2(NPIX + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  issue_idx;
  // [0]: address presented this cycle, [1]: ROM data on rom_data this cycle.
  logic [1:0]        inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [OCC_W-1:0]  occupancy;
  logic              accept, issue, push, pop, at_last_col, at_last_row, last_pop;

  // Pops are deliberately left out: counting only what is held or owed keeps
  // the check one cycle conservative but removes any overflow corner.
  assign occupancy   = OCC_W'(fifo_count) + OCC_W'(inflight[0]) + OCC_W'(inflight[1]);
  assign issue       = (state == FETCH) && (occupancy < OCC_W'(FIFO_DEPTH));
  // A start coinciding with the done pulse is dropped so back-to-back
  // requests always see a clean IDLE cycle.
  assign accept      = (state == IDLE) && start && !done;
  assign push        = inflight[1];
  assign pix_valid   = !fifo_empty;
  assign pop         = pix_valid && pix_ready;
  assign at_last_col = (pix_x == 5'(SPR_W-1));
  assign at_last_row = (pix_y == 5'(SPR_H-1));
  assign pix_last    = pix_valid && at_last_col && at_last_row;
  assign last_pop    = pop && at_last_col && at_last_row;

  sprite_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (push),
    .wr_data (rom_data),
    .pop     (pop),
    .rd_data (pix_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_addr  <= '0;
      base_q    <= '0;
      issue_idx <= '0;
      inflight  <= 2'b00;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= {inflight[0], accept | issue};

      // x/y tag the FIFO head, so they move only when the head leaves.
      if (pop) begin
        if (at_last_col) begin
          pix_x <= '0;
          pix_y <= at_last_row ? '0 : pix_y + 5'd1;
        end else begin
          pix_x <= pix_x + 5'd1;
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            base_q    <= base_addr;
            rom_addr  <= base_addr;
            issue_idx <= IDX_W'(1);
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            // Address space wraps silently at 2^ADDR_W.
            rom_addr  <= base_q + ADDR_W'(issue_idx);
            issue_idx <= issue_idx + 1'b1;
            if (issue_idx == IDX_W'(NPIX-1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: identity ROM, random backpressure, behavioural model.
// Latency: n/a.
// Backpressure: pix_ready driven either constantly high or at ~30% duty.
module tb_sprite_fetch;

  localparam int NPIX = 400;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [18:0] base_addr = '0;
  logic        busy, done;
  logic [18:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [23:0] pix_data;
  logic [4:0]  pix_x, pix_y;
  logic        pix_last;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;

  // Behavioural model: which sprite is active and which pixel index is at the head.
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_k = 0;
  logic [18:0] m_base = '0;
  int          acc_cyc = 0;
  logic        acc_valid = 1'b0;
  int          n_iss = 0;
  logic [18:0] last_addr = '0;
  logic        wrap_seen = 1'b0;
  logic        prev_stall = 1'b0;
  int          done_lat = 0;
  int          last_count = 0;
  logic [23:0] first_data = '0;

  sprite_fetch dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  // ROM with mem[i] = i and one cycle of registered read latency.
  always @(posedge Clk) rom_data <= {5'd0, rom_addr};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    #1;
    pix_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
  end

  // Compare process: sampled mid-cycle, then the model steps to the next edge.
  always @(negedge Clk) begin
    logic cur_busy, cur_done;
    if (!Reset_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_k = 0; acc_valid = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (done) done_lat = cyc - acc_cyc;
      if (m_done) chk("issued_count", n_iss, NPIX);
      if (acc_valid && m_busy) begin
        if (cyc == acc_cyc) begin
          chk("rom_addr_first", rom_addr, m_base);
          n_iss = 1;
          last_addr = rom_addr;
        end else if (rom_addr !== last_addr) begin
          chk("rom_addr_seq", rom_addr, 19'(m_base + 19'(n_iss)));
          if (last_addr == 19'h7FFFF && rom_addr == 19'h0) wrap_seen = 1'b1;
          n_iss++;
          last_addr = rom_addr;
        end
        if (cyc - acc_cyc <= 1) chk("valid_early", pix_valid, 0);
        else if (cyc - acc_cyc == 2) chk("valid_first", pix_valid, 1);
      end
      if (pix_valid) begin
        if (!m_busy) chk("valid_while_idle", pix_valid, 0);
        else begin
          chk("pix_data", pix_data, {5'd0, 19'(m_base + 19'(m_k))});
          chk("pix_x", pix_x, m_k % 20);
          chk("pix_y", pix_y, m_k / 20);
          chk("pix_last", pix_last, m_k == NPIX-1);
          if (m_k == 0) first_data = pix_data;
        end
      end
      if (prev_stall) chk("valid_hold", pix_valid, 1);
      prev_stall = pix_valid && !pix_ready;

      cur_busy = m_busy;
      cur_done = m_done;
      m_done = 1'b0;
      if (pix_valid && pix_ready && cur_busy) begin
        if (pix_last) last_count++;
        if (m_k == NPIX-1) begin
          m_busy = 1'b0; m_done = 1'b1; m_k = 0;
        end else m_k++;
      end
      if (start && !cur_busy && !cur_done) begin
        m_busy = 1'b1; m_base = base_addr; m_k = 0;
        acc_cyc = cyc + 1; acc_valid = 1'b1;
        wrap_seen = 1'b0; last_count = 0;
      end
    end
  end

  task automatic do_start(input logic [18:0] b);
    @(posedge Clk); #1;
    base_addr = b;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // Returns in the done cycle, after the compare process has sampled it.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("done_seen", done, 1);
    @(negedge Clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_pix_last"}, pix_last, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge Clk);
    #1;
    chk_reset_outputs("reset");
    Reset_n = 1'b1;

    // Full throughput from base 0.
    ready_mode = 0;
    do_start(19'd0);
    wait_done(1000);
    chk("t1_done_latency", done_lat, 402);
    chk("t1_first_pixel", first_data, 24'h000000);
    chk("t1_last_count", last_count, 1);

    // Second sprite in the ROM.
    do_start(19'd400);
    wait_done(1000);
    chk("t2_done_latency", done_lat, 402);
    chk("t2_first_pixel", first_data, 24'h000190);

    // Random backpressure, ignored starts, restart right after done.
    ready_mode = 1;
    do_start(19'd1000);
    repeat (60) @(posedge Clk);
    #1;
    base_addr = 19'd12345;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    wait_done(5000);
    chk("t3_last_count", last_count, 1);
    base_addr = 19'd2000;
    start = 1'b1;           // sampled with done high: must be ignored
    @(posedge Clk); #1;     // done now low: next edge accepts
    @(posedge Clk); #1;
    start = 1'b0;
    chk("t3_restart_busy", busy, 1);
    wait_done(5000);
    chk("t3_restart_first_pixel", first_data, 24'h0007D0);

    // Abort mid-fetch with an asynchronous reset.
    ready_mode = 0;
    do_start(19'd50);
    n = 0;
    while (m_k != 137 && n < 1000) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("t4_reached_px137", m_k, 137);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (5) @(posedge Clk);
    do_start(19'd60);
    wait_done(1000);
    chk("t4_first_pixel", first_data, 24'h00003C);
    chk("t4_done_latency", done_lat, 402);

    // Address wrap at the top of the ROM.
    do_start(19'h7FFF0);
    wait_done(1000);
    chk("t5_wrap_seen", wrap_seen, 1);
    chk("t5_done_latency", done_lat, 402);
    chk("t5_first_pixel", first_data, 24'h07FFF0);

    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
